// File: rtl/wb_pkg.sv
// Wishbone B4 cycle-type / burst-type constants and the burst master state encoding.
// Shared by the burst master and its address generator.
package wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR       = 2'b00;
   localparam logic [1:0] BTE_FOUR_BEAT    = 2'b01;
   localparam logic [1:0] BTE_EIGHT_BEAT   = 2'b10;
   localparam logic [1:0] BTE_SIXTEEN_BEAT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DONE  = 2'd2,
      ST_ABORT = 2'd3
   } state_t;

   // Low address bits that cycle inside a wrap window; linear bursts do not use it.
   function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
      logic [3:0] mask;
      mask = 4'b0000;
      case (bte)
         BTE_FOUR_BEAT:    mask = 4'b0011;
         BTE_EIGHT_BEAT:   mask = 4'b0111;
         BTE_SIXTEEN_BEAT: mask = 4'b1111;
         default:          mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Combinational next-word-address for Wishbone incrementing bursts (linear or wrapping).
// Kept standalone so a slave-side burst controller can predict addresses the same way.
module wb_burst_addr_gen
   import wb_pkg::*;
#(
   parameter int Aw   = 10,
   parameter int BTEw = 2
) (
   input  logic [Aw-1:0]   i_addr,
   input  logic [BTEw-1:0] i_bte,
   output logic [Aw-1:0]   o_next_addr
);

   logic [Aw-1:0] w_incr;
   logic [Aw-1:0] w_mask;

   assign w_incr = i_addr + Aw'(1);

   always_comb begin
      // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
      w_mask = '1;
      if (i_bte[1:0] != BTE_LINEAR) begin
         w_mask = Aw'(wrap_mask(i_bte[1:0]));
      end
   end

   // Bits outside the wrap window hold; bits inside take the incremented value and roll over.
   assign o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B4 burst master: one command becomes an incrementing burst, write data via a
// valid/ready stream with a single holding register, read data out as a valid-only stream.
module wb_burst_master
   import wb_pkg::*;
#(
   parameter int Dw   = 32,
   parameter int Aw   = 10,
   parameter int SELw = Dw / 8,
   parameter int CTIw = 3,
   parameter int BTEw = 2,
   parameter int LENw = 5
) (
   input  logic            clk,
   input  logic            reset,

   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_we,
   input  logic [Aw-1:0]   cmd_addr,
   input  logic [LENw-1:0] cmd_len,
   input  logic [BTEw-1:0] cmd_bte,
   input  logic [SELw-1:0] cmd_sel,

   input  logic [Dw-1:0]   wr_data,
   input  logic            wr_valid,
   output logic            wr_ready,

   output logic [Dw-1:0]   rd_data,
   output logic            rd_valid,
   output logic            rd_last,

   output logic [Aw-1:0]   m_addr_o,
   output logic [Dw-1:0]   m_dat_o,
   output logic [SELw-1:0] m_sel_o,
   output logic [CTIw-1:0] m_cti_o,
   output logic [BTEw-1:0] m_bte_o,
   output logic            m_stb_o,
   output logic            m_cyc_o,
   output logic            m_we_o,
   input  logic [Dw-1:0]   m_dat_i,
   input  logic            m_ack_i,
   input  logic            m_err_i,
   input  logic            m_rty_i,

   output logic            done,
   output logic            error,
   output logic            busy
);

   state_t          r_state;
   state_t          w_state_next;

   logic            r_we;
   logic [Aw-1:0]   r_addr;
   logic [BTEw-1:0] r_bte;
   logic [SELw-1:0] r_sel;
   logic [LENw-1:0] r_remaining;
   logic [LENw-1:0] r_loads_left;
   logic            r_hold_full;
   logic [Dw-1:0]   r_hold_data;

   logic            w_run;
   logic            w_stb;
   logic            w_fault;
   logic            w_beat;
   logic            w_last_beat;
   logic            w_accept;
   logic            w_wr_fire;
   logic [LENw-1:0] w_cmd_beats;
   logic [Aw-1:0]   w_addr_next;

   // Strobe depends only on registered state, so m_ack_i never reaches m_stb_o.
   assign w_run       = (r_state == ST_RUN);
   assign w_stb       = w_run & (~r_we | r_hold_full);
   assign w_fault     = w_run & (m_err_i | m_rty_i);
   assign w_beat      = w_stb & m_ack_i & ~w_fault;
   assign w_last_beat = w_beat & (r_remaining == LENw'(1));
   assign w_accept    = (r_state == ST_IDLE) & cmd_valid;
   assign w_wr_fire   = wr_valid & wr_ready;
   assign w_cmd_beats = (cmd_len == '0) ? LENw'(1) : cmd_len;

   wb_burst_addr_gen #(
      .Aw   (Aw),
      .BTEw (BTEw)
   ) u_addr_gen (
      .i_addr      (r_addr),
      .i_bte       (r_bte),
      .o_next_addr (w_addr_next)
   );

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      cmd_ready    = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      error        = 1'b0;
      m_cyc_o      = 1'b0;
      m_stb_o      = 1'b0;
      m_we_o       = 1'b0;
      m_cti_o      = CTIw'(CTI_CLASSIC);
      wr_ready     = 1'b0;
      rd_valid     = 1'b0;
      rd_last      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               w_state_next = ST_RUN;
            end
         end

         ST_RUN: begin
            m_cyc_o  = 1'b1;
            m_stb_o  = w_stb;
            m_we_o   = r_we;
            m_cti_o  = (r_remaining > LENw'(1)) ? CTIw'(CTI_INCR) : CTIw'(CTI_EOB);
            // The holding register can refill in the same cycle its beat is acknowledged.
            wr_ready = r_we & (r_loads_left != '0) & (~r_hold_full | w_beat);
            rd_valid = w_beat & ~r_we;
            rd_last  = w_beat & ~r_we & (r_remaining == LENw'(1));
            if (w_fault) begin
               w_state_next = ST_ABORT;
            end else if (w_last_beat) begin
               w_state_next = ST_DONE;
            end
         end

         ST_DONE: begin
            done         = 1'b1;
            w_state_next = ST_IDLE;
         end

         ST_ABORT: begin
            error        = 1'b1;
            w_state_next = ST_IDLE;
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ----------------------------------------------------- command / address
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_bte       <= '0;
         r_sel       <= '0;
         r_remaining <= '0;
      end else if (w_accept) begin
         r_we        <= cmd_we;
         r_addr      <= cmd_addr;
         r_bte       <= cmd_bte;
         r_sel       <= cmd_sel;
         r_remaining <= w_cmd_beats;
      end else if (w_beat) begin
         r_addr      <= w_addr_next;
         r_remaining <= r_remaining - LENw'(1);
      end
   end

   // ------------------------------------------------------------ write path
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hold_full  <= 1'b0;
         r_hold_data  <= '0;
         r_loads_left <= '0;
      end else if (w_accept) begin
         r_hold_full  <= 1'b0;
         r_loads_left <= cmd_we ? w_cmd_beats : '0;
      end else if (!w_run) begin
         // Data left over from an aborted burst is discarded.
         r_hold_full  <= 1'b0;
      end else if (w_wr_fire) begin
         r_hold_full  <= 1'b1;
         r_hold_data  <= wr_data;
         r_loads_left <= r_loads_left - LENw'(1);
      end else if (w_beat & r_we) begin
         r_hold_full  <= 1'b0;
      end
   end

   assign m_addr_o = r_addr;
   assign m_dat_o  = r_hold_data;
   assign m_sel_o  = r_sel;
   assign m_bte_o  = r_bte;
   assign rd_data  = m_dat_i;

endmodule
